ram_slot_arbiter: RTL
=====================

RAM_SLOT_ARBITER -- requirements
Module: ram_slot_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, range 1-15: odd slots a pending DMA request waits before stealing a CPU slot.
REQ-002 master_clock  in  1  25.175 MHz system clock; all logic on its rising edge; one clock = one slot.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 boot  in  1  high while the PIC loads RAM and the CPU is held; level.
REQ-005 blank  in  1  high during video h- or v-blanking; even slot free for DMA.
REQ-006 cpu_valid  in  1  CPU presents a valid address this cycle.
REQ-007 cpu_rw  in  1  CPU direction, 1 = read.
REQ-008 cpu_bank  in  4  CPU bank bits A16-A19.
REQ-009 dma_req  in  1  PIC-side DMA request, level, held until dma_ack.
REQ-010 dma_rw  in  1  DMA direction, 1 = read.
REQ-011 dma_bank  in  4  DMA bank bits A16-A19.
REQ-012 phi2  out  1  CPU clock; low = even slot, high = odd slot.
REQ-013 grant  out  2  slot owner: 00 idle, 01 video, 10 CPU, 11 DMA.
REQ-014 rdy  out  1  CPU RDY; low stretches the CPU cycle.
REQ-015 dma_ack  out  1  one-clock pulse, DMA access complete.
REQ-016 ram_a_n, ram_b_n, via_n, rd_n, wr_n  out  1 each  active-low chip selects and strobes.

Function
REQ-017 Internal phase bit SHALL toggle every clock; phi2 equals phase, registered.
REQ-018 Owner of slot n SHALL be decided from inputs sampled in slot n-1 and registered; all outputs registered, no combinational input-to-output paths.
REQ-019 Even slot: blank=0 -> video; blank=1 and DMA eligible -> DMA; else idle.
REQ-020 Odd slot, boot=1: DMA eligible -> DMA; else idle; CPU never granted.
REQ-021 Odd slot, boot=0: starve count >= STARVE_LIMIT and DMA eligible -> DMA with rdy=0 for that slot; else CPU if cpu_valid=1, else idle.
REQ-022 DMA eligible = dma_req=1 and dma_ack=0 in the deciding cycle (no double service).
REQ-023 Starve counter: 4-bit, increments per odd slot with DMA eligible and not granted, saturates at 15, clears on any DMA grant or dma_req=0.
REQ-024 Decode for CPU/DMA: bank[3]=0 -> ram_a_n=0; bank[3]=1 -> ram_b_n=0; CPU bank 0001 -> via_n=0 and ram_a_n=1; DMA never selects VIA.
REQ-025 Video slot: ram_a_n=0, rd_n=0, wr_n=1, others high.
REQ-026 Granted slot: rd_n = ~rw, wr_n = rw for the whole slot (write committed on rising wr_n at slot end); idle: all selects/strobes high.
REQ-027 dma_ack SHALL pulse high for exactly the clock following a DMA slot.
REQ-028 rdy SHALL be 1 in every slot except a stolen odd slot.
REQ-029 boot or blank changing mid-slot SHALL affect only the next decision.

Reset
REQ-030 While reset=1: phase=0, phi2=0, grant=00, rdy=1, dma_ack=0, all active-low outputs 1, starve counter 0.
REQ-031 First slot after reset release SHALL be even; reset during a DMA slot SHALL suppress its dma_ack (requester re-requests).

Configuration
REQ-032 Macro STARVE_STEAL_EN defined: REQ-021 stealing and REQ-023 counter present.
REQ-033 STARVE_STEAL_EN undefined: no counter, DMA only in blank even slots and boot odd slots, rdy constant 1.

Verification
REQ-034 Reset then boot=0, blank=0, cpu_valid=1, cpu_rw=1, cpu_bank=0100 -> grant alternates 01/10, ram_a_n=0 every slot, rd_n=0, wr_n=1.
REQ-035 boot=1, blank=1, dma_req=1, dma_rw=0, dma_bank=1000 -> DMA in consecutive even+odd slots, ram_b_n=0, wr_n=0, dma_ack one clock after each slot.
REQ-036 STARVE_STEAL_EN, STARVE_LIMIT=8, boot=0, blank=0, dma_req held -> 9th odd slot granted DMA with rdy=0, counter back to 0.
REQ-037 CPU cpu_bank=0001 write -> via_n=0, ram_a_n=1, ram_b_n=1, wr_n=0 in odd slot.
REQ-038 reset asserted during DMA slot -> dma_ack stays 0, outputs at REQ-030 values next clock.
REQ-039 STARVE_STEAL_EN undefined, dma_req held 100 clocks, blank=0, boot=0 -> no DMA grant, rdy=1 throughout.

Source files
------------

// File: rtl/ram_slot_arbiter.sv
// Slot arbiter for shared RAM: alternates video/CPU slots and fits PIC DMA into blank, boot and starved slots.
// Optional starvation-driven slot stealing is built when STARVE_STEAL_EN is defined.
module ram_slot_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       boot,
    input  logic       blank,
    input  logic       cpu_valid,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_bank,
    input  logic       dma_req,
    input  logic       dma_rw,
    input  logic [3:0] dma_bank,
    output logic       phi2,
    output logic [1:0] grant,
    output logic       rdy,
    output logic       dma_ack,
    output logic       ram_a_n,
    output logic       ram_b_n,
    output logic       via_n,
    output logic       rd_n,
    output logic       wr_n
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'b00,
        OWN_VIDEO = 2'b01,
        OWN_CPU   = 2'b10,
        OWN_DMA   = 2'b11
    } owner_t;

    localparam logic [3:0] VIA_BANK = 4'b0001;

    logic   phase_r;
    owner_t owner_s;
    logic   dma_elig_s;
    logic   rdy_s;
    logic   ram_a_s;
    logic   ram_b_s;
    logic   via_s;
    logic   rd_s;
    logic   wr_s;

`ifdef STARVE_STEAL_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_r;
    logic [3:0] starve_s;
    logic       steal_s;
`endif

    // Owner of the next slot; phase_r is the parity of the slot being decided.
    always_comb begin
        owner_s    = OWN_IDLE;
        dma_elig_s = dma_req & ~dma_ack;
`ifdef STARVE_STEAL_EN
        steal_s    = 1'b0;
`endif
        if (!phase_r) begin
            if (!blank) begin
                owner_s = OWN_VIDEO;
            end else if (dma_elig_s) begin
                owner_s = OWN_DMA;
            end else begin
                owner_s = OWN_IDLE;
            end
        end else if (boot) begin
            if (dma_elig_s) begin
                owner_s = OWN_DMA;
            end else begin
                owner_s = OWN_IDLE;
            end
        end else begin
`ifdef STARVE_STEAL_EN
            if ((starve_r >= LIMIT_C) && dma_elig_s) begin
                owner_s = OWN_DMA;
                steal_s = 1'b1;
            end else if (cpu_valid) begin
                owner_s = OWN_CPU;
            end else begin
                owner_s = OWN_IDLE;
            end
`else
            if (cpu_valid) begin
                owner_s = OWN_CPU;
            end else begin
                owner_s = OWN_IDLE;
            end
`endif
        end
    end

    // Chip-select and strobe decode for the chosen owner; DMA can never reach the VIA.
    always_comb begin
        ram_a_s = 1'b1;
        ram_b_s = 1'b1;
        via_s   = 1'b1;
        rd_s    = 1'b1;
        wr_s    = 1'b1;
        case (owner_s)
            OWN_VIDEO: begin
                ram_a_s = 1'b0;
                rd_s    = 1'b0;
            end
            OWN_CPU: begin
                if (cpu_bank == VIA_BANK) begin
                    via_s = 1'b0;
                end else if (cpu_bank[3]) begin
                    ram_b_s = 1'b0;
                end else begin
                    ram_a_s = 1'b0;
                end
                rd_s = ~cpu_rw;
                wr_s = cpu_rw;
            end
            OWN_DMA: begin
                if (dma_bank[3]) begin
                    ram_b_s = 1'b0;
                end else begin
                    ram_a_s = 1'b0;
                end
                rd_s = ~dma_rw;
                wr_s = dma_rw;
            end
            default: begin
                ram_a_s = 1'b1;
                ram_b_s = 1'b1;
                via_s   = 1'b1;
                rd_s    = 1'b1;
                wr_s    = 1'b1;
            end
        endcase
    end

`ifdef STARVE_STEAL_EN
    // Starvation count: only odd slots where an eligible request loses to the CPU advance it.
    always_comb begin
        starve_s = starve_r;
        rdy_s    = ~steal_s;
        if (!dma_req || (owner_s == OWN_DMA)) begin
            starve_s = 4'd0;
        end else if (phase_r && dma_elig_s && (starve_r != 4'hF)) begin
            starve_s = starve_r + 4'd1;
        end else begin
            starve_s = starve_r;
        end
    end
`else
    // Without stealing the CPU is never held off.
    always_comb begin
        rdy_s = 1'b1;
    end
`endif

    // Slot registers; every output comes straight from a flop.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            phase_r <= 1'b0;
            phi2    <= 1'b0;
            grant   <= OWN_IDLE;
            rdy     <= 1'b1;
            dma_ack <= 1'b0;
            ram_a_n <= 1'b1;
            ram_b_n <= 1'b1;
            via_n   <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
`ifdef STARVE_STEAL_EN
            starve_r <= 4'd0;
`endif
        end else begin
            phase_r <= ~phase_r;
            phi2    <= phase_r;
            grant   <= owner_s;
            rdy     <= rdy_s;
            dma_ack <= (grant == OWN_DMA);
            ram_a_n <= ram_a_s;
            ram_b_n <= ram_b_s;
            via_n   <= via_s;
            rd_n    <= rd_s;
            wr_n    <= wr_s;
`ifdef STARVE_STEAL_EN
            starve_r <= starve_s;
`endif
        end
    end

endmodule
